// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: FSM states, frame geometry and timing derivation.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RX,
    INHIBIT,
    START,
    WAIT_DEV,
    TX,
    ACK,
    DONE,
    ERROR
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS    = 11;
  // PS2_CLK must be seen high this many cycles before a fall is trusted
  localparam int unsigned GLITCH_CYCLES = 8;

  // 100 us host inhibit
  function automatic int unsigned inhibit_cycles(input int unsigned clk_freq_hz);
    return clk_freq_hz / 10000;
  endfunction

  // 15 ms for the device to start clocking after request-to-send
  function automatic int unsigned start_timeout_cycles(input int unsigned clk_freq_hz);
    return (clk_freq_hz / 1000) * 15;
  endfunction

  // 2 ms transfer budget / inter-bit gap
  function automatic int unsigned xfer_timeout_cycles(input int unsigned clk_freq_hz);
    return clk_freq_hz / 500;
  endfunction

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes PS2_CLK / PS2_DAT and produces a glitch-filtered PS2_CLK falling-edge pulse.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  localparam logic [3:0] HIGH_MIN = 4'(GLITCH_CYCLES);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic [3:0] high_cnt;

  // two-stage synchronizers plus a saturating count of consecutive high cycles on PS2_CLK
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      high_cnt <= '0;
    end else begin
      clk_ff <= {clk_ff[0], ps2_clk_in};
      dat_ff <= {dat_ff[0], ps2_dat_in};
      if (!clk_ff[1])
        high_cnt <= '0;
      else if (high_cnt != HIGH_MIN)
        high_cnt <= high_cnt + 4'd1;
    end
  end

  assign clk_sync = clk_ff[1];
  assign dat_sync = dat_ff[1];
  // a saturated count implies the previous cycle was high, so this is a clean 1->0
  assign clk_fall = ~clk_ff[1] & (high_cnt == HIGH_MIN);

endmodule

// File: rtl/ps2_host_controller.sv
// PS/2 host line controller: device-to-host byte receive and host-to-device command send.
//
// state    | meaning
// IDLE     | lines released, waiting for a start bit or a send request
// RX       | receiving a device frame
// INHIBIT  | host holds PS2_CLK low
// START    | host pulls PS2_DAT low, releases PS2_CLK
// WAIT_DEV | waiting for the device to start clocking
// TX       | shifting command bits out on device clock falls
// ACK      | expecting device to hold PS2_DAT low
// DONE     | command acknowledged, held until send_command drops
// ERROR    | timeout or missing ACK, held until send_command drops
module ps2_host_controller
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ          = 50_000_000,
  parameter int unsigned INHIBIT_CYCLES       = inhibit_cycles(CLK_FREQ_HZ),
  parameter int unsigned START_TIMEOUT_CYCLES = start_timeout_cycles(CLK_FREQ_HZ),
  parameter int unsigned XFER_TIMEOUT_CYCLES  = xfer_timeout_cycles(CLK_FREQ_HZ)
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 2);

  ps2_state_t  state, state_d;
  logic        clk_sync, dat_sync, clk_fall;
  logic [31:0] timer;
  logic [3:0]  bit_cnt;
  logic [8:0]  rx_sh;
  logic [9:0]  tx_bits;
  logic        tx_dat;
  logic        dat_low;

  ps2_line_sync u_line_sync (
    .clk        (CLOCK_50),
    .reset      (reset),
    .ps2_clk_in (PS2_CLK),
    .ps2_dat_in (PS2_DAT),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .clk_fall   (clk_fall)
  );

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // next-state and open-drain data drive
  always_comb begin
    state_d = state;
    dat_low = 1'b0;
    case (state)
      IDLE: begin
        if (send_command)               state_d = INHIBIT;
        else if (clk_fall && !dat_sync) state_d = RX;
      end
      RX: begin
        if (clk_fall) begin
          if (bit_cnt == LAST_BIT) state_d = IDLE;
        end else if (timer == '0) begin
          state_d = IDLE;
        end
      end
      INHIBIT: if (timer == '0) state_d = START;
      START: begin
        dat_low = 1'b1;
        state_d = WAIT_DEV;
      end
      WAIT_DEV: begin
        dat_low = 1'b1;
        if (clk_fall)           state_d = TX;
        else if (timer == '0)   state_d = ERROR;
      end
      TX: begin
        dat_low = ~tx_dat;
        if (clk_fall) begin
          if (bit_cnt == LAST_BIT) state_d = ACK;
        end else if (timer == '0) begin
          state_d = ERROR;
        end
      end
      ACK: begin
        if (clk_fall)         state_d = dat_sync ? ERROR : DONE;
        else if (timer == '0) state_d = ERROR;
      end
      DONE:    if (!send_command) state_d = IDLE;
      ERROR:   if (!send_command) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign PS2_CLK = (state == INHIBIT) ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  // timers, bit shifting, received byte and status flags
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      timer                         <= '0;
      bit_cnt                       <= '0;
      rx_sh                         <= '0;
      tx_bits                       <= '0;
      tx_dat                        <= 1'b1;
      received_data                 <= '0;
      received_data_en              <= 1'b0;
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= 1'b0;
    end else begin
      received_data_en <= 1'b0;

      // the transfer budget loaded on entering TX keeps running through ACK
      if (state_d != state) begin
        case (state_d)
          INHIBIT:  timer <= INHIBIT_CYCLES - 1;
          WAIT_DEV: timer <= START_TIMEOUT_CYCLES - 1;
          TX, RX:   timer <= XFER_TIMEOUT_CYCLES - 1;
          default:  ;
        endcase
      end else if (state == RX && clk_fall) begin
        timer <= XFER_TIMEOUT_CYCLES - 1;
      end else if (timer != '0) begin
        timer <= timer - 32'd1;
      end

      if (state == IDLE) begin
        bit_cnt <= '0;
        tx_dat  <= 1'b1;
        if (state_d == INHIBIT)
          tx_bits <= {1'b1, odd_parity(the_command), the_command};
      end

      if (clk_fall) begin
        case (state)
          RX: begin
            if (bit_cnt == LAST_BIT) begin
              if (dat_sync && (^rx_sh)) begin
                received_data    <= rx_sh[7:0];
                received_data_en <= 1'b1;
              end
            end else begin
              rx_sh <= {dat_sync, rx_sh[8:1]};
            end
            bit_cnt <= bit_cnt + 4'd1;
          end
          WAIT_DEV: begin
            tx_dat  <= tx_bits[0];
            bit_cnt <= 4'd1;
          end
          TX: begin
            tx_dat  <= tx_bits[bit_cnt];
            bit_cnt <= bit_cnt + 4'd1;
          end
          default: ;
        endcase
      end

      command_was_sent              <= (state_d == DONE) && (command_was_sent || (clk_sync && dat_sync));
      error_communication_timed_out <= (state_d == ERROR);
    end
  end

endmodule

// File: tb/tb_ps2_host_controller.sv
// Directed bench for ps2_host_controller with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_host_controller;

  localparam int unsigned CLK_FREQ = 500_000;  // scaled: inhibit 50, start timeout 7500, xfer 1000
  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] the_command = 8'h00;
  logic       send_command = 1'b0;
  wire        ps2_clk;
  wire        ps2_dat;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       command_was_sent;
  logic       error_communication_timed_out;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_controller #(.CLK_FREQ_HZ(CLK_FREQ)) dut (
    .CLOCK_50                      (CLOCK_50),
    .reset                         (reset),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .PS2_CLK                       (ps2_clk),
    .PS2_DAT                       (ps2_dat),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // strobe monitor: counts pulses, records values, tracks longest pulse
  int         strobes = 0;
  int         run_len = 0;
  int         max_run = 0;
  logic [7:0] rx_q[$];
  always @(negedge CLOCK_50) begin
    if (received_data_en === 1'b1) begin
      run_len++;
      if (run_len == 1) begin
        strobes++;
        rx_q.push_back(received_data);
      end
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  // host-driven PS2_CLK falls (one per request-to-send)
  int host_falls = 0;
  always @(negedge ps2_clk) if (!dev_clk_low) host_falls++;

  // device-to-host frame; nbits < 11 truncates the frame
  task automatic dev_send(input logic [7:0] d, input logic bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat_low = ~bits[i];
      repeat (HALF) @(posedge CLOCK_50);
      dev_clk_low = 1'b1;
      repeat (HALF) @(posedge CLOCK_50);
      dev_clk_low = 1'b0;
    end
    dev_dat_low = 1'b0;
    repeat (HALF) @(posedge CLOCK_50);
  endtask

  // host-to-device transfer as seen by the device, with ACK
  task automatic dev_recv(output logic [9:0] bits, output int inh_len, output logic start_bit, output bit ok);
    int n;
    ok = 1'b1; inh_len = 0; n = 0; bits = '0; start_bit = 1'b1;
    while (ps2_clk !== 1'b0 && n < 500) begin @(negedge CLOCK_50); n++; end
    if (n >= 500) begin ok = 1'b0; return; end
    while (ps2_clk === 1'b0 && inh_len < 20000) begin @(negedge CLOCK_50); inh_len++; end
    start_bit = ps2_dat;
    repeat (30) @(posedge CLOCK_50);
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(posedge CLOCK_50);
      if (i < 10) bits[i] = ps2_dat;
      dev_clk_low = 1'b0;
      if (i == 9) dev_dat_low = 1'b1;
      repeat (HALF) @(posedge CLOCK_50);
    end
    dev_dat_low = 1'b0;
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] tbits;
    int         inh;
    logic       sbit;
    bit         ok;
    int         cyc;
    int         s0;

    repeat (5) @(posedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check_eq("rst_data", received_data, 8'h00);
    check_eq("rst_en", received_data_en, 1'b0);
    check_eq("rst_sent", command_was_sent, 1'b0);
    check_eq("rst_err", error_communication_timed_out, 1'b0);
    check_eq("rst_clk_rel", ps2_clk, 1'b1);
    check_eq("rst_dat_rel", ps2_dat, 1'b1);
    repeat (20) @(posedge CLOCK_50);

    // single byte
    dev_send(8'h1C, 1'b0, 11);
    check_eq("rx1c_strobes", strobes, 1);
    check_eq("rx1c_val", (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx, 8'h1C);
    check_eq("rx1c_hold", received_data, 8'h1C);
    check_eq("strobe_width", max_run, 1);

    // back to back
    dev_send(8'hF0, 1'b0, 11);
    dev_send(8'h1C, 1'b0, 11);
    check_eq("b2b_strobes", strobes, 3);
    check_eq("b2b_val0", (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx, 8'hF0);
    check_eq("b2b_val1", (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx, 8'h1C);

    // parity error discarded, next frame good
    dev_send(8'h1C, 1'b1, 11);
    check_eq("par_no_strobe", strobes, 3);
    check_eq("par_data_kept", received_data, 8'h1C);
    dev_send(8'h29, 1'b0, 11);
    check_eq("after_par_val", (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx, 8'h29);
    check_eq("after_par_strobes", strobes, 4);

    // command send with ACK
    host_falls = 0;
    the_command = 8'hED;
    @(posedge CLOCK_50);
    send_command = 1'b1;
    dev_recv(tbits, inh, sbit, ok);
    check_eq("tx_started", ok, 1'b1);
    check_eq("tx_inhibit_len", inh, 50);
    check_eq("tx_start_bit", sbit, 1'b0);
    check_eq("tx_data", tbits[7:0], 8'hED);
    check_eq("tx_parity", tbits[8], 1'b1);
    check_eq("tx_stop", tbits[9], 1'b1);
    repeat (10) @(negedge CLOCK_50);
    check_eq("tx_sent", command_was_sent, 1'b1);
    check_eq("tx_no_err", error_communication_timed_out, 1'b0);
    repeat (300) @(negedge CLOCK_50);
    check_eq("tx_sent_held", command_was_sent, 1'b1);
    check_eq("tx_once", host_falls, 1);
    send_command = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_eq("tx_sent_clr", command_was_sent, 1'b0);

    // silent device -> timeout
    repeat (20) @(posedge CLOCK_50);
    send_command = 1'b1;
    cyc = 0;
    while (error_communication_timed_out !== 1'b1 && cyc < 9000) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check_eq("to_flag", error_communication_timed_out, 1'b1);
    check_eq("to_window", (cyc >= 7540 && cyc <= 7565), 1'b1);
    check_eq("to_clk_rel", ps2_clk, 1'b1);
    check_eq("to_dat_rel", ps2_dat, 1'b1);
    check_eq("to_not_sent", command_was_sent, 1'b0);
    send_command = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_eq("to_err_clr", error_communication_timed_out, 1'b0);

    // reset mid-frame
    repeat (20) @(posedge CLOCK_50);
    s0 = strobes;
    dev_send(8'h77, 1'b0, 5);
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    reset = 1'b0;
    repeat (HALF) @(negedge CLOCK_50);
    check_eq("midrst_no_strobe", strobes, s0);
    check_eq("midrst_data_clr", received_data, 8'h00);
    dev_send(8'h5A, 1'b0, 11);
    check_eq("midrst_next_strobes", strobes, s0 + 1);
    check_eq("midrst_next_val", (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
